// File: rtl/tsc_pkg.sv
// Shared types and constants for the transient-capture controller.
// Holds the state encoding, the default trigger threshold, the sample width
// and the default ring depth / pointer width.
package tsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_READOUT = 3'd4
  } tsc_state_e;

  localparam int         DATA_W       = 8;
  localparam logic [7:0] TRIGVL_DEF   = 8'hD5;
  localparam int         DEPTH_DEF    = 32;
  localparam int         PTR_W_DEF    = $clog2(DEPTH_DEF);
  localparam int         PRE_TRIG_DEF = 16;

endpackage

// File: rtl/tsc_capture_ctrl_if.sv
// Sample-in / readout-out bus of the transient-capture controller.
//   adc_req/adc_dat : sample strobe and 8-bit ADC sample (into the block)
//   rd_req          : readout word request (into the block)
//   rd_valid/rd_dat : readout word qualifier and data (out of the block)
// master = sample source / readout consumer, slave = tsc_capture_ctrl.
interface tsc_capture_ctrl_if;
  import tsc_pkg::*;

  logic              adc_req;
  logic [DATA_W-1:0] adc_dat;
  logic              rd_req;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_dat;

  modport master (output adc_req, adc_dat, rd_req, input rd_valid, rd_dat);
  modport slave  (input adc_req, adc_dat, rd_req, output rd_valid, rd_dat);

endinterface

// File: rtl/tsc_ring_ram.sv
// Capture ring storage: one write port, one read port, one-cycle read
// latency, contents never reset.
//   clk             : clock
//   wr_en/wr_addr/wr_dat : write port
//   rd_en/rd_addr   : read request, rd_dat valid the following cycle
module tsc_ring_ram
  import tsc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_dat,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/tsc_capture_ctrl.sv
// Transient-capture controller: fills a ring of DEPTH samples, keeps
// PRE_TRIG samples ahead of the first sample above TRIGVL, records the
// remaining post-trigger samples, then plays the window back oldest-first.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : adc_req/adc_dat in, rd_req in, rd_valid/rd_dat out
//   arm, abort  : start a capture / force IDLE
//   busy, done  : not-IDLE flag, one-cycle readout-complete pulse
//   state       : current state code
//   trig_forced : timeout produced the trigger (only with TSC_TIMEOUT_EN)
// Build option: define TSC_TIMEOUT_EN to bound the ARMED wait by TIMEOUT
// cycles; undefined, ARMED waits for a real trigger indefinitely.
module tsc_capture_ctrl
  import tsc_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEF,
  parameter int         PRE_TRIG = PRE_TRIG_DEF,
  parameter logic [7:0] TRIGVL   = TRIGVL_DEF,
  parameter int         TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  tsc_capture_ctrl_if.slave   bus,
  input  logic                arm,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state
`ifdef TSC_TIMEOUT_EN
  ,
  output logic                trig_forced
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] PRE_N  = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0] POST_N = CNT_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [CNT_W-1:0] RD_N   = CNT_W'(DEPTH);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 8 || DEPTH > 256) begin : g_bad_depth
    $error("DEPTH must be a power of two in 8..256");
  end
  if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 1) begin : g_bad_pre
    $error("PRE_TRIG must be in 1..DEPTH-1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  tsc_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, trig_ptr;
  logic [CNT_W-1:0]  fill_cnt, post_cnt, rd_cnt;
  logic              wr_en, rd_en, trig_hit, force_hit, arm_go, last_rd;
  logic              to_expire;
  logic              rd_vld_p1, done_p1;
  logic [DATA_W-1:0] ram_q;

  // Next-state and per-cycle strobes; abort overrides every decision.
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    trig_hit  = 1'b0;
    force_hit = 1'b0;
    arm_go    = 1'b0;
    last_rd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          arm_go  = 1'b1;
          state_d = ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        if (bus.adc_req) begin
          wr_en = 1'b1;
          if (fill_cnt + CNT_W'(1) >= PRE_N) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        trig_hit  = bus.adc_req && (bus.adc_dat > TRIGVL);
        // A real trigger in the expiry cycle wins; a forced trigger writes nothing.
        force_hit = to_expire && !trig_hit;
        wr_en     = bus.adc_req && !force_hit;
        if (trig_hit || force_hit) state_d = ST_POST;
      end
      ST_POST: begin
        if (post_cnt >= POST_N) begin
          state_d = ST_READOUT;
        end else if (bus.adc_req) begin
          wr_en = 1'b1;
          if (post_cnt + CNT_W'(1) >= POST_N) state_d = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if (bus.rd_req) begin
          rd_en = 1'b1;
          if (rd_cnt + CNT_W'(1) >= RD_N) begin
            last_rd = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      trig_hit  = 1'b0;
      force_hit = 1'b0;
      arm_go    = 1'b0;
      last_rd   = 1'b0;
    end
  end

  // Stage p0 -> p1: state, pointers, counters and the readout qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trig_ptr  <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
      rd_vld_p1 <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_p1 <= rd_en;
      done_p1   <= last_rd;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (arm_go) begin
        fill_cnt <= '0;
      end else if (state_q == ST_PREFILL && wr_en && fill_cnt < PRE_N) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
      if (trig_hit || force_hit) begin
        trig_ptr <= wr_ptr;
        post_cnt <= '0;
      end else if (state_q == ST_POST && wr_en && post_cnt < POST_N) begin
        post_cnt <= post_cnt + CNT_W'(1);
      end
      // Oldest kept sample sits PRE_TRIG slots behind the trigger slot.
      if (state_q == ST_POST && state_d == ST_READOUT) begin
        rd_ptr <= trig_ptr - PTR_W'(PRE_TRIG);
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (rd_cnt < RD_N) rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

`ifdef TSC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_expire = (state_q == ST_ARMED) && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      trig_forced <= 1'b0;
    end else begin
      if (state_q != ST_ARMED) begin
        to_cnt <= '0;
      end else if (to_cnt < TO_W'(TIMEOUT)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (arm_go) begin
        trig_forced <= 1'b0;
      end else if (force_hit) begin
        trig_forced <= 1'b1;
      end
    end
  end
`else
  assign to_expire = 1'b0;
`endif

  tsc_ring_ram #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_dat  (bus.adc_dat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_dat  (ram_q)
  );

  assign bus.rd_valid = rd_vld_p1;
  assign bus.rd_dat   = rd_vld_p1 ? ram_q : '0;
  assign done         = done_p1;
  assign busy         = (state_q != ST_IDLE);
  assign state        = state_q;

endmodule

// File: doc/tsc_capture_ctrl.md
TSC_CAPTURE_CTRL -- requirements
Module: tsc_capture_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, ring depth in samples; power of two, 8..256.
REQ-002 Parameter PRE_TRIG, default 16, samples kept before the trigger; range 1..DEPTH-1.
REQ-003 Parameter TRIGVL, default 8'hD5, trigger threshold; trigger is adc_dat > TRIGVL, unsigned.
REQ-004 Parameter TIMEOUT, default 1024, ARMED-state cycle limit (used only with TSC_TIMEOUT_EN).
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port adc_req  in  1  sample strobe; adc_dat is valid this cycle.
REQ-008 Port adc_dat  in  8  ADC sample.
REQ-009 Port arm  in  1  one-cycle pulse that starts a capture.
REQ-010 Port abort  in  1  forces the block to IDLE.
REQ-011 Port rd_req  in  1  readout word request.
REQ-012 Port rd_valid / rd_dat  out  1 / 8  readout word and its qualifier.
REQ-013 Port busy  out  1  high in every state except IDLE.
REQ-014 Port done  out  1  one-cycle pulse when readout completes.
REQ-015 Port state  out  3  current state encoding.
REQ-016 Port trig_forced  out  1  timeout caused the trigger (port exists only with TSC_TIMEOUT_EN).

Function
REQ-017 States: IDLE=0, PREFILL=1, ARMED=2, POST=3, READOUT=4; all other codes go to IDLE on the next cycle.
REQ-018 IDLE: arm -> PREFILL and fill count cleared; adc_req is ignored.
REQ-019 PREFILL: each adc_req writes ring[wr_ptr] and increments wr_ptr mod DEPTH; trigger compare disabled; after PRE_TRIG writes -> ARMED.
REQ-020 ARMED: writes continue; adc_req with adc_dat > TRIGVL writes that sample, latches trig_ptr=wr_ptr, clears post count, -> POST.
REQ-021 POST: after DEPTH-PRE_TRIG-1 further writes (trigger sample excluded) -> READOUT; the ring then holds exactly PRE_TRIG pre-trigger samples, the trigger sample and the post-trigger samples.
REQ-022 READOUT: rd_ptr starts at (trig_ptr-PRE_TRIG) mod DEPTH; each rd_req reads ring[rd_ptr] and increments rd_ptr; rd_valid/rd_dat follow one cycle after rd_req; adc_req is dropped.
REQ-023 After the DEPTH-th word is delivered: done pulses in the same cycle as the last rd_valid, state -> IDLE; rd_req in the IDLE cycle that follows is ignored.
REQ-024 arm outside IDLE is ignored; rd_req outside READOUT is ignored (rd_valid stays 0).
REQ-025 abort in any state -> IDLE next cycle, with priority over every other input; pointers are retained; no done pulse.
REQ-026 Pointer arithmetic is $clog2(DEPTH) bits wide and wraps naturally; counters saturate at their terminal value.

Reset
REQ-027 rst -> state IDLE; wr_ptr, rd_ptr, trig_ptr and counters 0; rd_valid, done, busy, trig_forced 0; rd_dat 8'h00.
REQ-028 Ring contents are not reset; rst mid-capture or mid-readout discards the capture with no done pulse.

Configuration
REQ-029 Macro TSC_TIMEOUT_EN defined: a counter counts ARMED cycles; when it reaches TIMEOUT, the block -> POST with trig_ptr=wr_ptr and no sample written, and trig_forced is set until the next arm or rst; a real trigger in the same cycle wins.
REQ-030 Macro undefined: no counter, no trig_forced port; ARMED waits indefinitely.

Structure
REQ-031 Package tsc_pkg holds the state enum, the default TRIGVL and the DEPTH/pointer-width constants.
REQ-032 Sub-module tsc_ring_ram: one write and one read port with one-cycle read latency, no reset, instanced once.

Verification
REQ-033 Arm; 16 samples of 8'h10, then 8'hE0, then 15 of 8'h20 -> READOUT; 32 rd_req give 16x10, E0, 15x20; done on word 32.
REQ-034 Sample 8'hD5 in ARMED -> no trigger; 8'hD6 -> trigger.
REQ-035 8'hFF during PREFILL -> ignored; state reaches ARMED only after 16 writes.
REQ-036 Second capture with trigger at wr_ptr=3 -> first readout word is ring[19]; wrap is correct.
REQ-037 abort during POST, and rst during READOUT -> IDLE next cycle, busy=0, no done.
REQ-038 With TSC_TIMEOUT_EN, TIMEOUT=8 and no trigger -> POST after 8 ARMED cycles with trig_forced=1; a trigger on cycle 8 gives trig_forced=0.
